// File: rtl/cr16_control_fsm.sv
// CR16 fetch/decode/execute controller: fetches over req/valid and drives the ALU controls.
// Latency: 3 cycles per instruction minimum. Stalls in FETCH for as long as instr_valid is low.
module cr16_control_fsm #(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] PC_RESET = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic              instr_req,
    output logic [DATA_W-1:0] instr_addr,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] instr_data,
    input  logic [4:0]        alu_flag,
    input  logic [DATA_W-1:0] alu_result,
    output logic [3:0]        ra,
    output logic [3:0]        rb,
    output logic [DATA_W-1:0] immediate,
    output logic [7:0]        OP,
    output logic              im_mux,
    output logic              pc_mux,
    output logic              regwrt,
    output logic [DATA_W-1:0] pc,
    output logic [4:0]        flag_reg
);

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_FETCH   = 2'd1,
        S_DECODE  = 2'd2,
        S_EXECUTE = 2'd3
    } state_t;

    state_t            state_q;
    logic              instr_req_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] pc_q;
    logic [3:0]        ra_q;
    logic [3:0]        rb_q;
    logic [DATA_W-1:0] imm_q;
    logic [7:0]        op_q;
    logic              im_mux_q;
    logic              pc_mux_q;
    logic              regwrt_q;
    logic [4:0]        flag_q;

    logic [3:0]        opc;
    logic [3:0]        ext;
    logic [3:0]        cond;
    logic [DATA_W-1:0] sext_imm;
    logic [DATA_W-1:0] dec_imm_d;
    logic [7:0]        dec_op_d;
    logic              dec_im_d;
    logic              dec_pcm_d;
    logic              dec_wr_d;
    logic              dec_setf_d;
    logic              dec_br_d;
    logic              taken;

    // The instruction register is held through EXECUTE, so decode stays combinational off it.
    always_comb begin
        opc        = ir_q[15:12];
        ext        = ir_q[7:4];
        cond       = ir_q[11:8];
        sext_imm   = {{8{ir_q[7]}}, ir_q[7:0]};
        dec_imm_d  = '0;
        dec_op_d   = 8'h00;
        dec_im_d   = 1'b0;
        dec_pcm_d  = 1'b0;
        dec_wr_d   = 1'b0;
        dec_setf_d = 1'b0;
        dec_br_d   = 1'b0;
        case (opc)
            4'h0: begin
                dec_op_d = {4'h0, ext};
                case (ext)
                    4'h1, 4'h2, 4'h3, 4'h5, 4'h9: begin
                        dec_wr_d   = 1'b1;
                        dec_setf_d = 1'b1;
                    end
                    4'hB:    dec_setf_d = 1'b1;
                    default: ;
                endcase
            end
            4'h1, 4'h2, 4'h3: begin
                dec_imm_d  = {8'h00, ir_q[7:0]};
                dec_op_d   = {opc, 4'h0};
                dec_im_d   = 1'b1;
                dec_wr_d   = 1'b1;
                dec_setf_d = 1'b1;
            end
            4'h5, 4'h9, 4'hB: begin
                dec_imm_d  = sext_imm;
                dec_op_d   = {opc, 4'h0};
                dec_im_d   = 1'b1;
                dec_wr_d   = (opc != 4'hB);
                dec_setf_d = 1'b1;
            end
            4'hC: begin
                dec_imm_d = sext_imm;
                dec_op_d  = 8'h50;
                dec_im_d  = 1'b1;
                dec_pcm_d = 1'b1;
                dec_br_d  = 1'b1;
            end
            default: ;
        endcase
        // Condition reads flag_q as left by the previous flag-setting instruction.
        taken = dec_br_d && (((cond == 4'h0) && flag_q[3]) ||
                             ((cond == 4'h1) && !flag_q[3]) ||
                              (cond == 4'hE));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_INIT;
            instr_req_q <= 1'b0;
            ir_q        <= '0;
            pc_q        <= PC_RESET;
            ra_q        <= '0;
            rb_q        <= '0;
            imm_q       <= '0;
            op_q        <= '0;
            im_mux_q    <= 1'b0;
            pc_mux_q    <= 1'b0;
            regwrt_q    <= 1'b0;
            flag_q      <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    instr_req_q <= 1'b1;
                    state_q     <= S_FETCH;
                end
                S_FETCH: begin
                    if (instr_valid) begin
                        ir_q        <= instr_data;
                        instr_req_q <= 1'b0;
                        state_q     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    ra_q     <= ir_q[11:8];
                    rb_q     <= ir_q[3:0];
                    imm_q    <= dec_imm_d;
                    op_q     <= dec_op_d;
                    im_mux_q <= dec_im_d;
                    pc_mux_q <= dec_pcm_d;
                    regwrt_q <= dec_wr_d;
                    state_q  <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    regwrt_q <= 1'b0;
                    if (dec_setf_d) begin
                        flag_q <= alu_flag;
                    end
                    pc_q        <= taken ? alu_result : pc_q + 16'd1;
                    instr_req_q <= 1'b1;
                    state_q     <= S_FETCH;
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign instr_req  = instr_req_q;
    assign instr_addr = pc_q;
    assign pc         = pc_q;
    assign ra         = ra_q;
    assign rb         = rb_q;
    assign immediate  = imm_q;
    assign OP         = op_q;
    assign im_mux     = im_mux_q;
    assign pc_mux     = pc_mux_q;
    assign regwrt     = regwrt_q;
    assign flag_reg   = flag_q;

endmodule

// File: doc/cr16_control_fsm.md
Name: cr16_control_fsm

Overview:
Multi-cycle fetch/decode/execute controller for the CR16 core. It fetches 16-bit instructions from instruction memory over a req/valid handshake and decodes them. It drives the ALU datapath control inputs: ra, rb, immediate, OP, im_mux, pc_mux, regwrt and pc. It latches the returned ALU flags and resolves conditional branches using the ALU result.

Parameters:
PC_RESET, 16'h0000, pc value loaded on reset.
DATA_W, 16, instruction/pc/immediate width; only 16 is supported.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
instr_req  output  1  high while requesting an instruction at instr_addr.
instr_addr  output  16  fetch address; always equals pc.
instr_valid  input  1  memory strobe; instr_data is valid when high.
instr_data  input  16  fetched instruction word.
alu_flag  input  5  ALU flags {N,Z,F,L,C} = bits [4:0]; bit 3 is Z.
alu_result  input  16  ALU output; used as the branch target.
ra  output  4  destination/first-source register index, instr[11:8].
rb  output  4  second-source register index, instr[3:0].
immediate  output  16  extended immediate.
OP  output  8  ALU operation code.
im_mux  output  1  1 = ALU B operand is immediate; 0 = register rb.
pc_mux  output  1  1 = ALU A operand is pc; 0 = register ra.
regwrt  output  1  one-cycle register-file write enable.
pc  output  16  program counter.
flag_reg  output  5  flags latched from the last flag-setting instruction.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=INIT; pc=PC_RESET.
  - All other outputs 0: instr_req, ra, rb, immediate, OP, im_mux, pc_mux, regwrt, flag_reg.
  - The instruction register clears to 0.
- States: INIT -> FETCH -> DECODE -> EXECUTE -> FETCH. INIT lasts exactly one cycle after reset release.
- FETCH:
  - instr_req=1.
  - On any edge with instr_valid=1: latch instr_data, go to DECODE, drop instr_req.
  - With instr_valid=0: stay in FETCH; wait is unbounded.
  - instr_valid outside FETCH is ignored.
- DECODE (1 cycle): register ra, rb, immediate, OP, im_mux, pc_mux from the latched instruction. regwrt=0.
- EXECUTE (1 cycle): controls held stable.
  - regwrt=1 for writing ops only.
  - Flag-setting ops latch alu_flag into flag_reg on the closing edge.
  - pc is updated on the closing edge.
- Minimum 3 cycles per instruction (FETCH with instr_valid already high, DECODE, EXECUTE).
- Decode fields: opc=instr[15:12], ext=instr[7:4], imm8=instr[7:0].
- opc=0 (register ALU):
  - OP={4'h0,ext}; im_mux=0; pc_mux=0; immediate=0.
  - ext in {1 AND, 2 OR, 3 XOR, 5 ADD, 9 SUB}: regwrt=1, flags latched.
  - ext=B (CMP): regwrt=0, flags latched.
  - Other ext: NOP.
- opc in {1 ANDI, 2 ORI, 3 XORI}: immediate={8'h00,imm8} (zero-extended); OP={opc,4'h0}; im_mux=1; regwrt=1; flags latched.
- opc in {5 ADDI, 9 SUBI}: immediate=sign-extended imm8; OP={opc,4'h0}; im_mux=1; regwrt=1; flags latched.
- opc=B (CMPI): same as ADDI/SUBI but regwrt=0; flags latched.
- opc=C (Bcond):
  - cond=instr[11:8]; immediate=sign-extended imm8.
  - pc_mux=1; im_mux=1; OP=8'h50 (ADD); regwrt=0; flags not updated.
  - Taken when: cond=0 and flag_reg[3]=1; cond=1 and flag_reg[3]=0; or cond=E (always). All other cond values are not taken.
  - Taken: pc<=alu_result. Not taken: pc<=pc+1.
- All other opcodes: NOP. regwrt=0, flags unchanged, pc<=pc+1.
- pc arithmetic is mod 2^16: 16'hFFFF+1 wraps to 16'h0000. Branch targets wrap identically.
- Branch condition uses flag_reg as it stood before this instruction. There is no same-cycle forwarding.
- Reset asserted mid-instruction (any state): immediate return to reset values. A pending fetch is abandoned and a write in progress is cancelled (regwrt forced 0).

Test Plan:
- Reset release, pc=0 -> INIT 1 cycle, then instr_req=1 with instr_addr=0; all control outputs 0 during reset.
- FETCH with instr_valid held 0 for 5 cycles, then 16'h0351 (ADD r3,r1) -> no state change while waiting. In EXECUTE: ra=3, rb=1, OP=8'h05, im_mux=0, regwrt=1 for exactly 1 cycle, pc 0->1.
- 16'h52FF (ADDI r2,-1) -> immediate=16'hFFFF, im_mux=1, OP=8'h50, regwrt=1. 16'h12FF (ANDI) -> immediate=16'h00FF.
- CMP with alu_flag=5'b01000, then 16'hC0FC (BEQ -4) at pc=16'h0010 with alu_result=16'h000C -> pc_mux=1, immediate=16'hFFFC, pc=16'h000C, regwrt=0. Same branch with Z=0 -> pc=16'h0011.
- pc=16'hFFFF executing a NOP (16'hF000) -> pc=16'h0000, flag_reg unchanged.
- Assert reset during EXECUTE of an ADD -> regwrt drops to 0 immediately, pc=PC_RESET, and the machine refetches from 0 after INIT.
